qdma_master: RTL and testbench

QBUS DMA bus-master engine for the QSIC: the initiator counterpart of the register-slave logic in the QBUS controller. Device controllers (RP11, RK11, …) post single-word read or write requests; the block arbitrates for the bus via DMR/DMG/SACK, runs the DATI or DATO cycle through the Am2908 transceiver controls, and reports completion or non-existent memory (NXM). It also drives TDMGO so that a grant the QSIC did not request continues down the daisy chain.

---
 rtl/qdma_master.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_qdma_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdma_master.sv
// QBUS DMA bus-master engine: arbitrates via DMR/DMG/SACK, runs single-word
// DATI/DATO cycles (bursting up to MAX_BURST words) and flags NXM on timeout.
module qdma_master #(
    parameter int ADDR_SETUP = 3,
    parameter int DATA_SETUP = 2,
    parameter int TIMEOUT    = 200,
    parameter int MAX_BURST  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_read_req,
    input  logic        dma_write_req,
    input  logic [21:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    output logic        dma_complete,
    output logic        dma_nxm,
    output logic        dma_bus_master,
    input  logic        RDMGI,
    input  logic        RSYNC,
    input  logic        RRPLY,
    input  logic [15:0] rdal,
    output logic        TDMR,
    output logic        TSACK,
    output logic        TDMGO,
    output logic        TSYNC,
    output logic        TDIN,
    output logic        TDOUT,
    output logic        dma_assert_dal,
    output logic [21:0] dma_dal,
    output logic        dma_dalbe,
    output logic        dma_daltx,
    output logic        dma_dalst
);
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [7:0]    ADDR_LAST = 8'(ADDR_SETUP);
    localparam logic [7:0]    DATA_LAST = 8'(DATA_SETUP - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] MAX_B     = BW'(MAX_BURST);

    typedef enum logic [3:0] {
        IDLE, REQ, WAITBUS, ADDR, ASYNC, DATA, RPLY, RPLYOFF, SYNCOFF, NEXT
    } state_t;

    // Bus receivers: index 0 = RDMGI, 1 = RSYNC, 2 = RRPLY.
    logic [2:0] raw_in;
    logic [2:0] sync_out;
    assign raw_in = {RRPLY, RSYNC, RDMGI};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [1:0] ff_reg;
            always_ff @(posedge clk) begin
                if (reset) ff_reg <= '0;
                else       ff_reg <= {ff_reg[0], raw_in[gi]};
            end
            assign sync_out[gi] = ff_reg[1];
        end
    endgenerate

    logic s_rdmgi, s_rsync, s_rrply, req;
    assign s_rdmgi = sync_out[0];
    assign s_rsync = sync_out[1];
    assign s_rrply = sync_out[2];
    assign req     = dma_read_req | dma_write_req;

    logic addr_unused;
    assign addr_unused = dma_addr[0];

    state_t        state_reg, state_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic [BW-1:0] burst_reg, burst_next;
    logic          dir_read_reg, dir_read_next;
    logic          nxm_flag_reg, nxm_flag_next;
    logic          rply_seen_reg, rply_seen_next;
    logic [15:0]   wdata_reg, wdata_next;
    logic [15:0]   rdata_reg, rdata_next;
    logic [21:0]   dal_reg, dal_next;
    logic          tdmr_reg, tdmr_next, tsack_reg, tsack_next, tdmgo_reg, tdmgo_next;
    logic          tsync_reg, tsync_next, tdin_reg, tdin_next, tdout_reg, tdout_next;
    logic          master_reg, master_next, assert_reg, assert_next;
    logic          dalbe_reg, dalbe_next, daltx_reg, daltx_next, dalst_reg, dalst_next;
    logic          complete_reg, complete_next, nxm_reg, nxm_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            tmo_reg       <= '0;
            burst_reg     <= '0;
            dir_read_reg  <= 1'b0;
            nxm_flag_reg  <= 1'b0;
            rply_seen_reg <= 1'b0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            dal_reg       <= '0;
            tdmr_reg      <= 1'b0;
            tsack_reg     <= 1'b0;
            tdmgo_reg     <= 1'b0;
            tsync_reg     <= 1'b0;
            tdin_reg      <= 1'b0;
            tdout_reg     <= 1'b0;
            master_reg    <= 1'b0;
            assert_reg    <= 1'b0;
            dalbe_reg     <= 1'b0;
            daltx_reg     <= 1'b0;
            dalst_reg     <= 1'b0;
            complete_reg  <= 1'b0;
            nxm_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            tmo_reg       <= tmo_next;
            burst_reg     <= burst_next;
            dir_read_reg  <= dir_read_next;
            nxm_flag_reg  <= nxm_flag_next;
            rply_seen_reg <= rply_seen_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            dal_reg       <= dal_next;
            tdmr_reg      <= tdmr_next;
            tsack_reg     <= tsack_next;
            tdmgo_reg     <= tdmgo_next;
            tsync_reg     <= tsync_next;
            tdin_reg      <= tdin_next;
            tdout_reg     <= tdout_next;
            master_reg    <= master_next;
            assert_reg    <= assert_next;
            dalbe_reg     <= dalbe_next;
            daltx_reg     <= daltx_next;
            dalst_reg     <= dalst_next;
            complete_reg  <= complete_next;
            nxm_reg       <= nxm_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + 8'd1;
        tmo_next       = (tmo_reg == '1) ? tmo_reg : tmo_reg + 1'b1;
        burst_next     = burst_reg;
        dir_read_next  = dir_read_reg;
        nxm_flag_next  = nxm_flag_reg;
        rply_seen_next = rply_seen_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        dal_next       = dal_reg;
        tdmr_next      = tdmr_reg;
        tsack_next     = tsack_reg;
        tdmgo_next     = tdmgo_reg;
        tsync_next     = tsync_reg;
        tdin_next      = tdin_reg;
        tdout_next     = tdout_reg;
        master_next    = master_reg;
        assert_next    = assert_reg;
        dalbe_next     = dalbe_reg;
        daltx_next     = daltx_reg;
        dalst_next     = 1'b0;
        complete_next  = 1'b0;
        nxm_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                // A grant we did not ask for is passed down the chain until it falls.
                tdmgo_next = s_rdmgi;
                if (!s_rdmgi && req) begin
                    tdmr_next  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (s_rdmgi) begin
                    tsack_next = 1'b1;
                    tdmr_next  = 1'b0;
                    tdmgo_next = 1'b0;
                    state_next = WAITBUS;
                end
            end
            WAITBUS: begin
                if (!s_rsync && !s_rrply) begin
                    master_next = 1'b1;
                    burst_next  = '0;
                    state_next  = ADDR;
                end
            end
            ADDR: begin
                if (cnt_reg == 8'd0) begin
                    dir_read_next  = dma_read_req;
                    wdata_next     = dma_wdata;
                    dal_next       = {dma_addr[21:1], 1'b0};
                    assert_next    = 1'b1;
                    daltx_next     = 1'b1;
                    dalbe_next     = 1'b1;
                    dalst_next     = 1'b1;
                    nxm_flag_next  = 1'b0;
                    rply_seen_next = 1'b0;
                end
                if (cnt_reg == ADDR_LAST) begin
                    tsync_next = 1'b1;
                    tmo_next   = '0;
                    state_next = ASYNC;
                end
            end
            ASYNC: begin
                if (cnt_reg == 8'd1) begin
                    if (dir_read_reg) begin
                        daltx_next = 1'b0;
                        dalbe_next = 1'b0;
                        tdin_next  = 1'b1;
                        state_next = RPLY;
                    end else begin
                        dal_next   = {6'b0, wdata_reg};
                        dalst_next = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt_reg == DATA_LAST) begin
                    tdout_next = 1'b1;
                    state_next = RPLY;
                end
            end
            RPLY: begin
                // Read data is captured one clock after the synchronized reply.
                if (dir_read_reg && rply_seen_reg) begin
                    rdata_next = rdal;
                    tdin_next  = 1'b0;
                    state_next = RPLYOFF;
                end else if (!dir_read_reg && s_rrply) begin
                    tdout_next = 1'b0;
                    state_next = RPLYOFF;
                end else if (tmo_reg >= TMO_LAST) begin
                    tdin_next     = 1'b0;
                    tdout_next    = 1'b0;
                    nxm_flag_next = 1'b1;
                    state_next    = SYNCOFF;
                end else if (dir_read_reg && s_rrply) begin
                    rply_seen_next = 1'b1;
                end
            end
            RPLYOFF: begin
                if (!s_rrply) state_next = SYNCOFF;
            end
            SYNCOFF: begin
                tsync_next    = 1'b0;
                complete_next = 1'b1;
                nxm_next      = nxm_flag_reg;
                burst_next    = burst_reg + 1'b1;
                state_next    = NEXT;
            end
            NEXT: begin
                if (req && (burst_reg < MAX_B) && !nxm_flag_reg) begin
                    state_next = ADDR;
                end else begin
                    tsack_next  = 1'b0;
                    master_next = 1'b0;
                    assert_next = 1'b0;
                    dalbe_next  = 1'b0;
                    daltx_next  = 1'b0;
                    dal_next    = '0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next != state_reg) cnt_next = '0;
    end

    assign dma_rdata      = rdata_reg;
    assign dma_complete   = complete_reg;
    assign dma_nxm        = nxm_reg;
    assign dma_bus_master = master_reg;
    assign TDMR           = tdmr_reg;
    assign TSACK          = tsack_reg;
    assign TDMGO          = tdmgo_reg;
    assign TSYNC          = tsync_reg;
    assign TDIN           = tdin_reg;
    assign TDOUT          = tdout_reg;
    assign dma_assert_dal = assert_reg;
    assign dma_dal        = dal_reg;
    assign dma_dalbe      = dalbe_reg;
    assign dma_daltx      = daltx_reg;
    assign dma_dalst      = dalst_reg;
endmodule

// File: tb/tb_qdma_master.sv
// Bench for qdma_master: arbiter and slave models, table of transactions,
// scoreboard checked on every dma_complete, plus pass-through and reset sequences.
module tb_qdma_master;
    localparam int ADDR_SETUP = 3;
    localparam int DATA_SETUP = 2;
    localparam int TIMEOUT    = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        dma_read_req, dma_write_req;
    logic [21:0] dma_addr;
    logic [15:0] dma_wdata;
    logic [15:0] dma_rdata;
    logic        dma_complete, dma_nxm, dma_bus_master;
    logic        RDMGI, RSYNC, RRPLY;
    logic [15:0] rdal;
    logic        TDMR, TSACK, TDMGO, TSYNC, TDIN, TDOUT;
    logic        dma_assert_dal, dma_dalbe, dma_daltx, dma_dalst;
    logic [21:0] dma_dal;

    qdma_master #(.ADDR_SETUP(ADDR_SETUP), .DATA_SETUP(DATA_SETUP),
                  .TIMEOUT(TIMEOUT), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .dma_read_req(dma_read_req), .dma_write_req(dma_write_req),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
        .dma_complete(dma_complete), .dma_nxm(dma_nxm), .dma_bus_master(dma_bus_master),
        .RDMGI(RDMGI), .RSYNC(RSYNC), .RRPLY(RRPLY), .rdal(rdal),
        .TDMR(TDMR), .TSACK(TSACK), .TDMGO(TDMGO), .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT),
        .dma_assert_dal(dma_assert_dal), .dma_dal(dma_dal), .dma_dalbe(dma_dalbe),
        .dma_daltx(dma_daltx), .dma_dalst(dma_dalst)
    );

    always #25 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [15:0] sdata;
        int          lat;
        bit          respond;
    } vec_t;

    typedef struct {
        bit          rd;
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        bit          nxm;
    } exp_t;

    vec_t        tbl [14];
    exp_t        sb [$];
    int          tenure_q [$];
    int          checks = 0, failures = 0;
    int          pushes = 0, completes = 0, violations = 0;
    logic [15:0] model_rdata = 16'h0;

    // Bus-side models
    logic        arb_en = 1'b1, arb_dmg = 1'b0, man_dmg = 1'b0;
    logic        slv_respond = 1'b0;
    int          slv_lat = 0, lat_cnt = 0;
    logic [15:0] slv_data = 16'h0;
    assign RDMGI = arb_en ? arb_dmg : man_dmg;
    assign RSYNC = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=expired_or_unexpected required=in_bound", name);
    endtask

    // Monitor, scoreboard, arbiter and slave all share one negedge process so the
    // monitor always sees bus levels before the models react to them.
    int          cyc = 0, tsync_cyc = 0, dal_stable = 0, words_cur = 0;
    logic [21:0] prev_dal = '0, addr_seen = '0;
    logic [15:0] wdata_seen = '0;
    logic        prev_tsync = 0, prev_tdin = 0, prev_tdout = 0, prev_tsack = 0;
    logic        prev_complete = 0, prev_dalst = 0, prev_reset = 1;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (dma_dal == prev_dal) dal_stable++;
        else                     dal_stable = 1;
        if (!reset && !prev_reset) begin
            if (TSYNC && !prev_tsync) begin
                check("addr_setup_ge3", 32'(dal_stable - 1 >= ADDR_SETUP), 1);
                addr_seen = dma_dal;
                tsync_cyc = cyc;
            end
            if (TDOUT && !prev_tdout) begin
                check("data_setup_ge2", 32'(dal_stable - 1 >= DATA_SETUP), 1);
                wdata_seen = dma_dal[15:0];
            end
            if (sb.size() > 0) begin
                if (!TDOUT && prev_tdout && !sb[0].nxm) check("tdout_fall_in_rply", 32'(RRPLY), 1);
                if (!TDIN && prev_tdin) begin
                    if (sb[0].nxm) check("nxm_tdin_at_timeout", 32'(cyc - tsync_cyc), TIMEOUT);
                    else           check("tdin_fall_in_rply", 32'(RRPLY), 1);
                end
                if (!TSYNC && prev_tsync && !sb[0].nxm) check("tsync_fall_after_rply", 32'(RRPLY), 0);
            end
            if (dma_complete) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_complete");
                end else begin
                    e = sb.pop_front();
                    check("cmp_nxm", 32'(dma_nxm), 32'(e.nxm));
                    check("cmp_rdata", 32'(dma_rdata), 32'(e.rdata));
                    check("cmp_addr", 32'(addr_seen), 32'(e.addr));
                    if (!e.rd) check("cmp_wdata", 32'(wdata_seen), 32'(e.wdata));
                    $display("TXN %s addr=%06o wdata=%06o rdata=%06o nxm=%0d",
                             e.rd ? "DATI" : "DATO", e.addr, wdata_seen, dma_rdata, dma_nxm);
                end
                completes++;
                words_cur++;
            end
            if (dma_nxm && !dma_complete)       violations++;
            if (dma_complete && prev_complete)  violations++;
            if (dma_dalst && prev_dalst)        violations++;
            if (TDMGO && (TSACK || TDMR))       violations++;
        end
        if (TSACK && !prev_tsack) words_cur = 0;
        if (!TSACK && prev_tsack) tenure_q.push_back(words_cur);

        if (TSACK)     arb_dmg = 1'b0;
        else if (TDMR) arb_dmg = 1'b1;

        if ((TDIN || TDOUT) && slv_respond) begin
            if (lat_cnt >= slv_lat) begin
                RRPLY = 1'b1;
                rdal  = slv_data;
            end else begin
                lat_cnt++;
            end
        end else begin
            RRPLY   = 1'b0;
            rdal    = 16'h0;
            lat_cnt = 0;
        end

        prev_dal = dma_dal;       prev_tsync = TSYNC;   prev_tdin = TDIN;
        prev_tdout = TDOUT;       prev_tsack = TSACK;   prev_complete = dma_complete;
        prev_dalst = dma_dalst;   prev_reset = reset;
    end

    task automatic post(input int i);
        exp_t e;
        dma_read_req  = tbl[i].rd;
        dma_write_req = !tbl[i].rd;
        dma_addr      = tbl[i].addr;
        dma_wdata     = tbl[i].wdata;
        slv_data      = tbl[i].sdata;
        slv_lat       = tbl[i].lat;
        slv_respond   = tbl[i].respond;
        if (tbl[i].rd && tbl[i].respond) model_rdata = tbl[i].sdata;
        e.rd    = tbl[i].rd;
        e.addr  = tbl[i].addr & 22'h3FFFFE;
        e.wdata = tbl[i].wdata;
        e.rdata = model_rdata;
        e.nxm   = !tbl[i].respond;
        sb.push_back(e);
        pushes++;
    endtask

    task automatic finish_burst(input int lo, input int hi);
        int idx = lo;
        int budget = 0;
        while (idx <= hi && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (dma_complete) begin
                idx++;
                budget = 0;
                if (idx <= hi) post(idx);
                else begin
                    dma_read_req  = 1'b0;
                    dma_write_req = 1'b0;
                end
            end
        end
        if (idx <= hi) begin
            fail_now("burst_timeout");
            dma_read_req  = 1'b0;
            dma_write_req = 1'b0;
        end
    endtask

    task automatic run_burst(input int lo, input int hi);
        post(lo);
        finish_burst(lo, hi);
    endtask

    task automatic expect_tenure(input int words);
        repeat (5) @(negedge clk);
        if (tenure_q.size() == 0) fail_now("tenure_missing");
        else check("tenure_words", 32'(tenure_q.pop_front()), 32'(words));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({TDMR, TSACK, TDMGO, TSYNC, TDIN, TDOUT, dma_complete, dma_nxm,
               dma_bus_master, dma_assert_dal, dma_dalbe, dma_daltx, dma_dalst}), 0);
        check({tag, "_dal"}, 32'(dma_dal), 0);
        check({tag, "_rdata"}, 32'(dma_rdata), 0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit tdmr_seen, found;
        //          rd    addr          wdata      sdata       lat respond
        tbl[0]  = '{1'b1, 22'o17700,    16'h0,     16'o123456, 4, 1'b1};
        tbl[1]  = '{1'b0, 22'o1000,     16'o54321, 16'h0,      2, 1'b1};
        tbl[2]  = '{1'b1, 22'o17701,    16'h0,     16'hA5A5,   0, 1'b1};
        tbl[3]  = '{1'b0, 22'h3FFFFE,   16'hFFFF,  16'h0,      7, 1'b1};
        tbl[4]  = '{1'b1, 22'o777000,   16'h0,     16'hBEEF,   0, 1'b0};
        tbl[5]  = '{1'b1, 22'o4000,     16'h0,     16'h0F0F,   1, 1'b1};
        tbl[6]  = '{1'b0, 22'o10000,    16'h1111,  16'h0,      1, 1'b1};
        tbl[7]  = '{1'b1, 22'o10002,    16'h0,     16'h2222,   2, 1'b1};
        tbl[8]  = '{1'b0, 22'o10004,    16'h3333,  16'h0,      0, 1'b1};
        tbl[9]  = '{1'b1, 22'o10006,    16'h0,     16'h4444,   3, 1'b1};
        tbl[10] = '{1'b0, 22'o10010,    16'h5555,  16'h0,      1, 1'b1};
        tbl[11] = '{1'b1, 22'o10012,    16'h0,     16'h6666,   0, 1'b1};
        tbl[12] = '{1'b1, 22'o2000,     16'h0,     16'h1234,   3, 1'b1};
        tbl[13] = '{1'b1, 22'o1234,     16'h0,     16'h55AA,   1, 1'b1};

        reset = 1'b1;
        dma_read_req = 1'b0; dma_write_req = 1'b0;
        dma_addr = '0; dma_wdata = '0;
        RRPLY = 1'b0; rdal = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_burst(i, i);
            expect_tenure(1);
        end
        run_burst(4, 5);            // NXM releases the bus; next word re-arbitrates
        expect_tenure(1);
        expect_tenure(1);
        run_burst(6, 11);           // six words: four per tenure, then two
        expect_tenure(4);
        expect_tenure(2);

        // Grant pass-through, then a request raised while the foreign grant is high
        arb_en = 1'b0; man_dmg = 1'b1;
        @(negedge clk);
        check("pt_tdmgo_early", 32'(TDMGO), 0);
        repeat (3) @(negedge clk);
        check("pt_tdmgo_on", 32'(TDMGO), 1);
        post(13);
        tdmr_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (TDMR) tdmr_seen = 1'b1;
        end
        check("pt_no_tdmr_in_grant", 32'(tdmr_seen), 0);
        check("pt_tdmgo_held", 32'(TDMGO), 1);
        man_dmg = 1'b0; arb_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (TDMR) found = 1'b1;
        end
        check("pt_tdmr_after_grant", 32'(found), 1);
        check("pt_tdmgo_off", 32'(TDMGO), 0);
        finish_burst(13, 13);
        expect_tenure(1);

        // Reset while waiting for a slow reply: no completion, everything cleared
        dma_read_req = 1'b1; dma_addr = 22'o4000;
        slv_respond = 1'b1; slv_lat = 30; slv_data = 16'hDEAD;
        for (int i = 0; i < 200 && !TDIN; i++) @(negedge clk);
        if (!TDIN) fail_now("rst_wait_tdin");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        model_rdata = 16'h0;
        dma_read_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        expect_tenure(0);

        run_burst(12, 12);
        expect_tenure(1);

        check("protocol_violations", 32'(violations), 0);
        check("complete_count", 32'(completes), 32'(pushes));
        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
